// File: rtl/mul_op_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_op_ctrl
//  Description : Issue/retire controller for an external sequential unsigned
//                multiplier. Accepts MUL/MULH/MULHSU/MULHU requests, sends
//                operand magnitudes to the multiplier, waits a fixed latency,
//                sign-corrects the unsigned product and returns the chosen half.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_op_ctrl #(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = XLEN + 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    // request channel
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [1:0]          i_req_op,
    input  logic [XLEN-1:0]     i_req_rs1,
    input  logic [XLEN-1:0]     i_req_rs2,
    input  logic [4:0]          i_req_rd,
    // multiplier interface
    output logic [XLEN-1:0]     o_mul_a,
    output logic [XLEN-1:0]     o_mul_b,
    output logic                o_mul_L,
    input  logic [2*XLEN-1:0]   i_mul_y,
    // response channel
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [XLEN-1:0]     o_rsp_data,
    output logic [4:0]          o_rsp_rd,
    output logic                o_busy
);

    localparam int CW = $clog2(MUL_LAT + 1);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LOAD = 3'd1;
    localparam logic [2:0] c_ST_RUN  = 3'd2;
    localparam logic [2:0] c_ST_FIX  = 3'd3;
    localparam logic [2:0] c_ST_RESP = 3'd4;

    localparam logic [1:0] c_OP_MUL    = 2'b00;
    localparam logic [1:0] c_OP_MULH   = 2'b01;
    localparam logic [1:0] c_OP_MULHSU = 2'b10;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(MUL_LAT - 1);

    logic [2:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic [4:0]         r_rd;
    logic               r_neg;
    logic [2*XLEN-1:0]  r_prod;
    logic [XLEN-1:0]    r_mul_a;
    logic [XLEN-1:0]    r_mul_b;
    logic               r_rsp_valid;
    logic [XLEN-1:0]    r_rsp_data;
    logic [4:0]         r_rsp_rd;

    logic               w_accept;
    logic               w_s1;
    logic               w_s2;
    logic [XLEN-1:0]    w_mag1;
    logic [XLEN-1:0]    w_mag2;
    logic [2*XLEN-1:0]  w_prod_fix;
    logic [XLEN-1:0]    w_res;

    // Operand sign decode: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
    // MUL needs no sign handling since the low half is sign-invariant.
    always_comb begin
        w_accept = (r_state == c_ST_IDLE) && i_req_valid;
        w_s1     = i_req_rs1[XLEN-1] & ((i_req_op == c_OP_MULH) || (i_req_op == c_OP_MULHSU));
        w_s2     = i_req_rs2[XLEN-1] & (i_req_op == c_OP_MULH);
        // Magnitude of the most negative value wraps to 2^(XLEN-1), which is
        // exactly representable as an unsigned XLEN quantity.
        w_mag1   = w_s1 ? (XLEN'(0) - i_req_rs1) : i_req_rs1;
        w_mag2   = w_s2 ? (XLEN'(0) - i_req_rs2) : i_req_rs2;
        w_prod_fix = r_neg ? ((2*XLEN)'(0) - r_prod) : r_prod;
        w_res    = (r_op == c_OP_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
    end

    // Sequencer: IDLE -> LOAD -> RUN -> FIX -> RESP -> IDLE, with latency counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    r_state <= c_ST_RUN;
                    r_cnt   <= '0;
                end
                c_ST_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    r_state <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    // Returning to IDLE here means a request offered on the
                    // handshake edge is seen only from the following cycle.
                    if (i_rsp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: latch request, capture product at end of RUN, publish result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op        <= '0;
            r_rd        <= '0;
            r_neg       <= 1'b0;
            r_prod      <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_rd    <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= i_req_op;
                r_rd    <= i_req_rd;
                r_neg   <= w_s1 ^ w_s2;
                r_mul_a <= w_mag1;
                r_mul_b <= w_mag2;
            end
            if ((r_state == c_ST_RUN) && (r_cnt == c_CNT_LAST)) begin
                r_prod <= i_mul_y;
            end
            if (r_state == c_ST_FIX) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_res;
                r_rsp_rd    <= r_rd;
            end else if ((r_state == c_ST_RESP) && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_req_ready = (r_state == c_ST_IDLE);
    assign o_busy      = (r_state != c_ST_IDLE);
    assign o_mul_L     = (r_state == c_ST_LOAD);
    assign o_mul_a     = r_mul_a;
    assign o_mul_b     = r_mul_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_rd    = r_rsp_rd;

endmodule
`default_nettype wire

// File: tb/tb_mul_op_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_op_ctrl
//  Description : Directed, table-driven bench for mul_op_ctrl with a
//                behavioural fixed-latency multiplier attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_op_ctrl;

    localparam int XLEN    = 64;
    localparam int MUL_LAT = XLEN + 1;
    localparam int LAT_EXP = MUL_LAT + 2;
    localparam logic [127:0] c_JUNK = {4{32'hA5A5_5A5A}};

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [XLEN-1:0]    req_rs1;
    logic [XLEN-1:0]    req_rs2;
    logic [4:0]         req_rd;
    logic [XLEN-1:0]    mul_a;
    logic [XLEN-1:0]    mul_b;
    logic               mul_L;
    logic [2*XLEN-1:0]  mul_y;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [XLEN-1:0]    rsp_data;
    logic [4:0]         rsp_rd;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    mul_op_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_rs1   (req_rs1),
        .i_req_rs2   (req_rs2),
        .i_req_rd    (req_rd),
        .o_mul_a     (mul_a),
        .o_mul_b     (mul_b),
        .o_mul_L     (mul_L),
        .i_mul_y     (mul_y),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_rd    (rsp_rd),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: samples operands on the load edge, shows junk
    // while working, and presents a*b so it is sampled on edge load+MUL_LAT.
    logic [XLEN-1:0] m_a, m_b;
    int m_cnt = 0;
    always @(posedge clk) begin
        if (mul_L) begin
            m_a   <= mul_a;
            m_b   <= mul_b;
            m_cnt <= 1;
            mul_y <= c_JUNK;
        end else if (m_cnt != 0) begin
            if (m_cnt == MUL_LAT - 1) begin
                mul_y <= {64'd0, m_a} * {64'd0, m_b};
                m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [4:0]  rd;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int stall, input string tag);
        int cyc;
        int lpulse;
        cyc = 0;
        while (!req_ready && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = v.op; req_rs1 = v.rs1; req_rs2 = v.rs2; req_rd = v.rd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_rs1 = '1; req_rs2 = '1;
        chk({tag, " mul_a"}, mul_a, v.ea);
        chk({tag, " mul_b"}, mul_b, v.eb);
        cyc = 0; lpulse = 0;
        while (!rsp_valid && cyc < 200) begin
            if (mul_L) lpulse++;
            @(posedge clk); #1; cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(LAT_EXP));
        chk({tag, " load_pulses"}, 64'(lpulse), 64'd1);
        chk({tag, " mul_a_held"}, mul_a, v.ea);
        chk({tag, " rsp_data"}, rsp_data, v.exp);
        chk({tag, " rsp_rd"}, 64'(rsp_rd), 64'(v.rd));
        if (stall > 0) begin
            // Offer a competing request while the response is stalled.
            req_valid = 1'b1; req_op = 2'b11; req_rs1 = 64'd9; req_rs2 = 64'd9; req_rd = 5'd1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                chk({tag, " stall_valid"}, 64'(rsp_valid), 64'd1);
                chk({tag, " stall_data"}, rsp_data, v.exp);
                chk({tag, " stall_rd"}, 64'(rsp_rd), 64'(v.rd));
                chk({tag, " stall_req_ready"}, 64'(req_ready), 64'd0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({tag, " rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
        chk({tag, " busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, " rsp_data"}, rsp_data, 64'd0);
        chk({tag, " rsp_rd"}, 64'(rsp_rd), 64'd0);
        chk({tag, " mul_a"}, mul_a, 64'd0);
        chk({tag, " mul_b"}, mul_b, 64'd0);
        chk({tag, " mul_L"}, 64'(mul_L), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        int seen;
        vec_t v;
        //          op     rs1                     rs2                     rd     |a|                     |b|                     result
        vecs[0]  = '{2'b00, 64'd3,                  -64'sd5,                5'd3,  64'd3,                  64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[1]  = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
        vecs[2]  = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[3]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6,  64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  5'd7,  64'd1,                  64'd0,                  64'd0};
        vecs[5]  = '{2'b01, -64'sd3,                64'd5,                  5'd8,  64'd3,                  64'd5,                  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6]  = '{2'b01, 64'h4000_0000_0000_0000, 64'd4,                  5'd9,  64'h4000_0000_0000_0000, 64'd4,                  64'd1};
        vecs[7]  = '{2'b10, 64'd2,                  64'h8000_0000_0000_0000, 5'd10, 64'd2,                  64'h8000_0000_0000_0000, 64'd1};
        vecs[8]  = '{2'b11, 64'h8000_0000_0000_0000, 64'd2,                  5'd11, 64'h8000_0000_0000_0000, 64'd2,                  64'd1};
        vecs[9]  = '{2'b00, 64'd7,                  64'd6,                  5'd12, 64'd7,                  64'd6,                  64'd42};
        vecs[10] = '{2'b01, -64'sd7,                -64'sd6,                5'd13, 64'd7,                  64'd6,                  64'd0};
        vecs[11] = '{2'b00, 64'h1_0000_0000,         64'h1_0000_0000,         5'd14, 64'h1_0000_0000,         64'h1_0000_0000,         64'd0};
        vecs[12] = '{2'b10, -64'sd2,                64'd3,                  5'd31, 64'd2,                  64'd3,                  64'hFFFF_FFFF_FFFF_FFFF};

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0;
        req_rd = '0; rsp_ready = 1'b0; mul_y = c_JUNK;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Response back-pressure for 10 cycles with a competing request.
        run_txn(vecs[5], 10, "stall");

        // Reset in the middle of RUN aborts the operation.
        req_valid = 1'b1; req_op = 2'b01; req_rs1 = -64'sd9; req_rs2 = 64'd9; req_rd = 5'd17;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrun busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || busy) seen++;
        end
        chk("aborted no_rsp", 64'(seen), 64'd0);
        v = '{2'b00, 64'd7, 64'd6, 5'd2, 64'd7, 64'd6, 64'd42};
        run_txn(v, 0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
